dbus_wait_bridge: RTL and testbench

- CPU data-bus target that fronts a slow, variable-latency peripheral port (external SRAM/flash controller, slow register file) with a req/ack handshake.
- Sits behind one enable output of the data-bus address decoder, like any other target. Returns read data and a Nak stall signal exactly as the decoder expects.
- Converts the single-cycle bus strobe into a held request, stalls the CPU until the device acks, and times out hung devices with a sticky error record.

---
 rtl/dbus_wait_bridge.sv | 133 +++++++++++++
 tb/tb_dbus_wait_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_wait_bridge.sv
// Data-bus target that turns a one-cycle bus strobe into a held req/ack
// transaction to a slow peripheral, stalling the CPU and timing out hung devices.
//
// state | meaning
// IDLE  | no access in flight, dataOut holds last result
// WAIT  | devReq held, nak asserted, waiting for devAck or timeout
// DONE  | access complete this cycle, nak low, new en may start next access
module dbus_wait_bridge #(
   parameter int          ADDR_W       = 20,
   parameter int          TIMEOUT      = 255,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [31:0]       addrBus,
   input  logic              we,
   input  logic [3:0]        byteEn,
   input  logic [31:0]       dataIn,
   output logic [31:0]       dataOut,
   output logic              nak,
   output logic              devReq,
   output logic              devWe,
   output logic [ADDR_W-1:0] devAddr,
   output logic [3:0]        devByteEn,
   output logic [31:0]       devWdata,
   input  logic              devAck,
   input  logic [31:0]       devRdata,
   output logic              errFlag,
   output logic [31:0]       errAddr,
   input  logic              errClear
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      capAddr;
   logic             startTxn;
   logic             ackHit;
   logic             timeoutHit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext  = state;
      startTxn   = 1'b0;
      ackHit     = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (en) begin
               startTxn  = 1'b1;
               stateNext = WAIT;
            end else begin
               stateNext = IDLE;
            end
         end
         WAIT: begin
            // A device ack in the last permitted cycle still counts as success.
            if (devAck) begin
               ackHit    = 1'b1;
               stateNext = DONE;
            end else if (cnt == CNT_LAST) begin
               timeoutHit = 1'b1;
               stateNext  = DONE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign nak = (state == WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dataOut   <= '0;
         devReq    <= 1'b0;
         devWe     <= 1'b0;
         devAddr   <= '0;
         devByteEn <= '0;
         devWdata  <= '0;
         capAddr   <= '0;
         cnt       <= '0;
         errFlag   <= 1'b0;
         errAddr   <= '0;
      end else begin
         if (startTxn) begin
            devReq    <= 1'b1;
            devWe     <= we;
            devAddr   <= addrBus[ADDR_W+1:2];
            devByteEn <= byteEn;
            devWdata  <= dataIn;
            capAddr   <= addrBus;
            cnt       <= '0;
         end else if (ackHit) begin
            devReq  <= 1'b0;
            dataOut <= devWe ? 32'h0 : devRdata;
         end else if (timeoutHit) begin
            devReq  <= 1'b0;
            dataOut <= devWe ? 32'h0 : TIMEOUT_DATA;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end

         // Keep the first failing address unless software is clearing the
         // record in the very cycle a new timeout lands.
         if (timeoutHit) begin
            errFlag <= 1'b1;
            if (!errFlag || errClear) begin
               errAddr <= capAddr;
            end
         end else if (errClear) begin
            errFlag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dbus_wait_bridge.sv
// Directed bench for dbus_wait_bridge: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_dbus_wait_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] addrBus;
   logic        we;
   logic [3:0]  byteEn;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        nak;
   logic        devReq;
   logic        devWe;
   logic [19:0] devAddr;
   logic [3:0]  devByteEn;
   logic [31:0] devWdata;
   logic        devAck;
   logic [31:0] devRdata;
   logic        errFlag;
   logic [31:0] errAddr;
   logic        errClear;

   int vectors = 0;
   int miscompares = 0;

   dbus_wait_bridge #(.ADDR_W(20), .TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst), .en(en), .addrBus(addrBus), .we(we), .byteEn(byteEn),
      .dataIn(dataIn), .dataOut(dataOut), .nak(nak), .devReq(devReq), .devWe(devWe),
      .devAddr(devAddr), .devByteEn(devByteEn), .devWdata(devWdata), .devAck(devAck),
      .devRdata(devRdata), .errFlag(errFlag), .errAddr(errAddr), .errClear(errClear)
   );

   always #5 clk = ~clk;

   // Reference model: one in-flight access with an age in WAIT cycles (1-based).
   bit          mBusy = 0;
   int          mAge = 0;
   logic [31:0] mData = 0, mAddr = 0, mErrAddr = 0, mWd = 0;
   bit          mErr = 0, mWe = 0;
   logic [3:0]  mBe = 0;
   bit          wasBusy, tmo;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mBusy = 0; mAge = 0; mData = 0; mAddr = 0; mErrAddr = 0;
         mWd = 0; mErr = 0; mWe = 0; mBe = 0;
      end else begin
         wasBusy = mBusy;
         tmo = 0;
         if (wasBusy) begin
            if (devAck) begin
               mBusy = 0;
               mData = mWe ? 32'h0 : devRdata;
            end else if (mAge == TMO) begin
               mBusy = 0;
               tmo = 1;
               mData = mWe ? 32'h0 : 32'hDEADBEEF;
            end else begin
               mAge++;
            end
         end
         if (tmo) begin
            if (!mErr || errClear) mErrAddr = mAddr;
            mErr = 1;
         end else if (errClear) begin
            mErr = 0;
         end
         if (!wasBusy && en) begin
            mBusy = 1; mAge = 1; mAddr = addrBus; mWe = we; mBe = byteEn; mWd = dataIn;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmpCycle();
      chk("nak",       32'(nak),       32'(mBusy));
      chk("devReq",    32'(devReq),    32'(mBusy));
      chk("dataOut",   dataOut,        mData);
      chk("devWe",     32'(devWe),     32'(mWe));
      chk("devAddr",   32'(devAddr),   32'(mAddr[21:2]));
      chk("devByteEn", 32'(devByteEn), 32'(mBe));
      chk("devWdata",  devWdata,       mWd);
      chk("errFlag",   32'(errFlag),   32'(mErr));
      chk("errAddr",   errAddr,        mErrAddr);
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      we = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Called just after a posedge; presents the access in this cycle and acts as
   // the device. Returns in the completion cycle with en still asserted.
   task automatic busTxn(input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] d, input int ackDelay, input logic [31:0] rdata,
                         input int clrCycle, output int nakCyc, output logic [31:0] rdOut,
                         output logic reqAt1, output logic [19:0] addrAt1);
      bit done;
      done = 0;
      nakCyc = 0; rdOut = 0; reqAt1 = 0; addrAt1 = 0;
      en = 1'b1; addrBus = a; we = w; byteEn = be; dataIn = d; devAck = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            reqAt1 = devReq;
            addrAt1 = devAddr;
         end
         if (!mBusy) begin
            nakCyc = k - 1;
            rdOut = dataOut;
            devAck = 1'b0;
            errClear = 1'b0;
            done = 1;
            break;
         end
         devAck = ((k - 1) == ackDelay);
         devRdata = rdata;
         errClear = (k == clrCycle);
      end
      if (!done) begin
         devAck = 1'b0;
         errClear = 1'b0;
         chk("txn_done_within_budget", 32'd0, 32'd1);
      end
   endtask

   int          nc, nc2;
   logic [31:0] rd, rd2;
   logic        r1;
   logic [19:0] a1;

   initial begin
      rst = 1'b0; en = 1'b0; addrBus = 0; we = 1'b0; byteEn = 0; dataIn = 0;
      devAck = 1'b0; devRdata = 0; errClear = 1'b0;
      fork
         forever begin
            @(negedge clk);
            cmpCycle();
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            chk("rst_dataOut", dataOut, 32'h0);
            chk("rst_nak", 32'(nak), 32'd0);
            chk("rst_devReq", 32'(devReq), 32'd0);
            chk("rst_errFlag", 32'(errFlag), 32'd0);
            chk("rst_errAddr", errAddr, 32'h0);
            rst = 1'b1;
            idle(1);

            // read, ack three cycles after devReq rises
            busTxn(32'h00048D14, 1'b0, 4'hF, 32'h0, 3, 32'h12345678, -1, nc, rd, r1, a1);
            chk("rd_nak_cycles", 32'(nc), 32'd4);
            chk("rd_data", rd, 32'h12345678);
            chk("rd_devAddr", 32'(a1), 32'h12345);
            idle(2);

            // write acked in the first WAIT cycle
            busTxn(32'hBFA00010, 1'b1, 4'b0011, 32'hCAFEF00D, 0, 32'h99999999, -1, nc, rd, r1, a1);
            chk("wr_nak_cycles", 32'(nc), 32'd1);
            chk("wr_devWe", 32'(devWe), 32'd1);
            chk("wr_devByteEn", 32'(devByteEn), 32'd3);
            chk("wr_devWdata", devWdata, 32'hCAFEF00D);
            chk("wr_dataOut", rd, 32'h0);
            idle(1);

            // back-to-back: second en presented in the DONE cycle
            busTxn(32'h00000100, 1'b0, 4'hF, 32'h0, 0, 32'hAAAA0001, -1, nc, rd, r1, a1);
            chk("b2b_first_data", rd, 32'hAAAA0001);
            busTxn(32'h00000204, 1'b1, 4'hC, 32'h00000055, 1, 32'h0, -1, nc2, rd2, r1, a1);
            chk("b2b_req_no_idle", 32'(r1), 32'd1);
            chk("b2b_new_addr", 32'(a1), 32'h81);
            chk("b2b_nak_cycles", 32'(nc2), 32'd2);
            idle(2);

            // hung device
            busTxn(32'h00000ABC, 1'b0, 4'hF, 32'h0, -1, 32'h0, -1, nc, rd, r1, a1);
            chk("to_nak_cycles", 32'(nc), 32'd8);
            chk("to_data", rd, 32'hDEADBEEF);
            chk("to_errFlag", 32'(errFlag), 32'd1);
            chk("to_errAddr", errAddr, 32'h00000ABC);
            en = 1'b0; devAck = 1'b1; devRdata = 32'h11111111;
            @(posedge clk); #1;
            devAck = 1'b0;
            chk("late_ack_data", dataOut, 32'hDEADBEEF);
            chk("late_ack_req", 32'(devReq), 32'd0);
            idle(1);
            busTxn(32'h000003F0, 1'b1, 4'hF, 32'h12121212, -1, 32'h0, -1, nc, rd, r1, a1);
            chk("to2_nak_cycles", 32'(nc), 32'd8);
            chk("to2_errAddr_kept", errAddr, 32'h00000ABC);
            chk("to2_write_data", rd, 32'h0);
            en = 1'b0;
            errClear = 1'b1;
            @(posedge clk); #1;
            errClear = 1'b0;
            chk("clr_errFlag", 32'(errFlag), 32'd0);
            idle(1);

            // ack in the final permitted cycle wins over timeout
            busTxn(32'h00000050, 1'b0, 4'hF, 32'h0, 7, 32'h0BADF00D, -1, nc, rd, r1, a1);
            chk("coinc_data", rd, 32'h0BADF00D);
            chk("coinc_errFlag", 32'(errFlag), 32'd0);
            idle(1);

            // errClear in the timeout cycle: set wins
            busTxn(32'h00000060, 1'b0, 4'hF, 32'h0, -1, 32'h0, 8, nc, rd, r1, a1);
            chk("clr_to_errFlag", 32'(errFlag), 32'd1);
            chk("clr_to_errAddr", errAddr, 32'h00000060);
            idle(1);

            // reset in the middle of WAIT
            en = 1'b1; addrBus = 32'h00000070; we = 1'b0; byteEn = 4'hF;
            @(posedge clk); #1;
            @(posedge clk); #1;
            #1 rst = 1'b0;
            #1;
            chk("mid_rst_nak", 32'(nak), 32'd0);
            chk("mid_rst_devReq", 32'(devReq), 32'd0);
            chk("mid_rst_errFlag", 32'(errFlag), 32'd0);
            en = 1'b0;
            #3 rst = 1'b1;
            @(posedge clk); #1;
            busTxn(32'h00000080, 1'b0, 4'hF, 32'h0, 1, 32'hFEEDFACE, -1, nc, rd, r1, a1);
            chk("post_rst_nak_cycles", 32'(nc), 32'd2);
            chk("post_rst_data", rd, 32'hFEEDFACE);
            chk("post_rst_addr", 32'(a1), 32'h20);
            idle(2);
         end
      join_any
      disable fork;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
